up_sample_affine_controller: RTL

// - Schedule generator driving one port of an up_sample unified buffer (hw_input_stencil_ub / nearest_neighbor_stencil_ub).
// - Walks a 3-deep rectangular loop nest and emits per-cycle wen/ren plus ctrl_vars[2:0] (d0 outermost, d2 innermost).
// - Two instances per buffer (write side, read side); the buffer consumes the generated ctrl_vars unchanged.

---
 rtl/up_sample_affine_controller_pkg.sv | 20 ++
 rtl/up_sample_affine_controller_counter.sv | 32 +++
 rtl/up_sample_affine_controller.sv | 109 ++++++++++
 3 files changed

// File: rtl/up_sample_affine_controller_pkg.sv
// Shared types for the unified-buffer schedule controllers.
//   CTRL_W       width of each loop-nest coordinate
//   NDIMS        depth of the loop nest
//   ctrl_state_t controller FSM states
//   ctrl_var_t   one loop-nest coordinate
package ub_ctrl_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned NDIMS  = 3;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } ctrl_state_t;

  typedef logic [CTRL_W-1:0] ctrl_var_t;

endpackage

// File: rtl/up_sample_affine_controller_counter.sv
// One dimension of the affine loop nest: a wrapping counter over 0..EXTENT-1.
//   clk, rst_n  clock / asynchronous active-low reset
//   inc         advance by one (wraps to 0 from EXTENT-1)
//   clr         synchronous clear to 0, has priority over inc
//   value       current coordinate
//   at_last     value == EXTENT-1
module affine_loop_counter
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned EXTENT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [CTRL_W-1:0] value,
  output logic              at_last
);

  assign at_last = (value == ctrl_var_t'(EXTENT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_last ? '0 : value + ctrl_var_t'(1);
    end
  end

endmodule

// File: rtl/up_sample_affine_controller.sv
// Schedule generator for one port of an up_sample unified buffer. Walks a
// 3-deep rectangular loop nest (d0 outermost, d2 innermost) and emits one
// point every II cycles after a START_DELAY lead-in.
//   clk, rst_n  clock / asynchronous active-low reset
//   flush       synchronous schedule restart (overrides stall)
//   stall       freeze all progress this cycle
//   valid       wen/ren strobe for the buffer port
//   ctrl_vars   current loop-nest point, [0]=d0 .. [2]=d2
//   last        valid point is the final point of the nest
//   done        nest complete; held until flush or reset
module up_sample_affine_controller
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned EXTENT_0    = 1,
  parameter int unsigned EXTENT_1    = 128,
  parameter int unsigned EXTENT_2    = 128,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned II          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl_vars [NDIMS-1:0],
  output logic              last,
  output logic              done
);

  ctrl_state_t state, state_nxt;
  ctrl_var_t   delay_cnt;
  ctrl_var_t   ii_cnt;
  logic        at_last0, at_last1, at_last2;
  logic        adv;

  // The final point must not advance the counters: they hold (E0-1,E1-1,E2-1)
  // in DONE instead of wrapping d0 past its extent.
  assign adv = valid && !last;

  affine_loop_counter #(.EXTENT(EXTENT_0)) u_d0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (adv && at_last2 && at_last1),
    .clr     (flush),
    .value   (ctrl_vars[0]),
    .at_last (at_last0)
  );

  affine_loop_counter #(.EXTENT(EXTENT_1)) u_d1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (adv && at_last2),
    .clr     (flush),
    .value   (ctrl_vars[1]),
    .at_last (at_last1)
  );

  affine_loop_counter #(.EXTENT(EXTENT_2)) u_d2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (adv),
    .clr     (flush),
    .value   (ctrl_vars[2]),
    .at_last (at_last2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // With no lead-in the flush jumps straight to RUN so the first point lands
  // on the first cycle after flush drops.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = (START_DELAY == 0) ? RUN : DELAY;
    end else if (!stall) begin
      case (state)
        DELAY:   if (32'(delay_cnt) + 32'd1 == START_DELAY) state_nxt = RUN;
        RUN:     if (last) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_cnt <= '0;
      ii_cnt    <= '0;
    end else if (flush) begin
      delay_cnt <= '0;
      ii_cnt    <= '0;
    end else if (!stall) begin
      if (state == DELAY) delay_cnt <= delay_cnt + ctrl_var_t'(1);
      if (state == RUN) ii_cnt <= (ii_cnt == ctrl_var_t'(II - 1)) ? '0 : ii_cnt + ctrl_var_t'(1);
    end
  end

  always_comb begin
    valid = (state == RUN) && (ii_cnt == '0) && !stall && !flush;
    last  = valid && at_last0 && at_last1 && at_last2;
    done  = (state == DONE);
  end

endmodule
